// File: rtl/i2s_rx.sv
// i2s_rx: slave-mode I2S receiver.
//   Brings the external BCLK/LRCK/SD into the clk domain through 2-FF
//   synchronizers. On every detected BCLK rising edge it deserializes MSB-first
//   words per channel, with the standard one-BCLK delay after each LRCK
//   transition. Each completed word is pushed to the receive FIFO write port.
//
// Parameters
//   DATA_W  captured word width (must be <= SLOT_W-1, and >= 2)
//   SLOT_W  maximum BCLK periods per LRCK half-frame
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   enable            receiver enable; low forces the receiver back to seeking
//   bclk_in, lrck_in, sd_in   asynchronous I2S inputs (LRCK 0 = left)
//   fifo_full         downstream FIFO full
//   wr_en, wr_data, wr_chan   one-cycle write strobe with word and channel
//   overrun           sticky: a completed word was dropped (FIFO full)
//   frame_err         sticky: short or long half-frame seen
//   clr_err           clears both sticky flags (a new error in the same cycle wins)
module i2s_rx #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              bclk_in,
  input  logic              lrck_in,
  input  logic              sd_in,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_chan,
  output logic              overrun,
  output logic              frame_err,
  input  logic              clr_err
);

  localparam int CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SLOT = CNT_W'(SLOT_W);

  typedef enum logic {SEEK, RECV} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
  logic              chan, chan_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              word_done, ferr_set;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic lrck_s1, lrck_s2;
  logic sd_s1, sd_s2;
  logic lrck_prev;
  logic rise, lrck_chg;

  assign rise     = bclk_s2 & ~bclk_s3;
  assign lrck_chg = lrck_s2 ^ lrck_prev;
  assign cnt_inc  = (cnt == CNT_SLOT) ? cnt : cnt + 1'b1;

  // Protocol stage: decides the next state on each BCLK rise
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chan_nxt  = chan;
    shift_nxt = shift;
    word_done = 1'b0;
    ferr_set  = 1'b0;
    if (!enable) begin
      state_nxt = SEEK;
      cnt_nxt   = '0;
    end else if (rise) begin
      case (state)
        SEEK: begin
          if (lrck_chg) begin
            state_nxt = RECV;
            cnt_nxt   = '0;
            chan_nxt  = lrck_s2;
          end
        end
        RECV: begin
          if (lrck_chg) begin
            // A boundary before the full word arrived: drop the partial word.
            if (cnt < CNT_DATA) ferr_set = 1'b1;
            cnt_nxt  = '0;
            chan_nxt = lrck_s2;
          end else begin
            // The first rise after the boundary (cnt = 0) carries the MSB.
            if (cnt < CNT_DATA) shift_nxt = {shift[DATA_W-2:0], sd_s2};
            if (cnt == CNT_LAST) word_done = 1'b1;
            cnt_nxt = cnt_inc;
            if (cnt_inc == CNT_SLOT) begin
              ferr_set  = 1'b1;
              state_nxt = SEEK;
            end
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_s3   <= 1'b0;
      lrck_s1   <= 1'b0;
      lrck_s2   <= 1'b0;
      sd_s1     <= 1'b0;
      sd_s2     <= 1'b0;
      lrck_prev <= 1'b0;
      state     <= SEEK;
      cnt       <= '0;
      chan      <= 1'b0;
      shift     <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      wr_chan   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Synchronizer stage
      bclk_s1 <= bclk_in;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lrck_s1 <= lrck_in;
      lrck_s2 <= lrck_s1;
      sd_s1   <= sd_in;
      sd_s2   <= sd_s1;

      // Protocol stage registers; lrck_prev tracks even while disabled so a
      // re-enable has to wait for a genuinely new boundary.
      if (rise) lrck_prev <= lrck_s2;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      chan  <= chan_nxt;
      shift <= shift_nxt;

      // Output stage
      wr_en <= word_done & ~fifo_full;
      if (word_done && !fifo_full) begin
        wr_data <= shift_nxt;
        wr_chan <= chan;
      end
      if (word_done && fifo_full) overrun <= 1'b1;
      else if (clr_err)           overrun <= 1'b0;
      if (ferr_set)               frame_err <= 1'b1;
      else if (clr_err)           frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed bench for i2s_rx (DATA_W=24, SLOT_W=32, BCLK = clk/16).
module tb_i2s_rx;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst, enable, bclk_in, lrck_in, sd_in, fifo_full, clr_err;
  logic          wr_en, wr_chan, overrun, frame_err;
  logic [DW-1:0] wr_data;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int dbl_wr = 0;
  logic prev_wr = 1'b0;

  logic [DW-1:0] wq_data[$];
  logic          wq_chan[$];
  int            wq_cyc[$];
  int            lsb_q[$];

  i2s_rx #(.DATA_W(DW), .SLOT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bclk_in(bclk_in), .lrck_in(lrck_in),
    .sd_in(sd_in), .fifo_full(fifo_full), .wr_en(wr_en), .wr_data(wr_data),
    .wr_chan(wr_chan), .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every write away from the active edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wq_data.push_back(wr_data);
      wq_chan.push_back(wr_chan);
      wq_cyc.push_back(cyc);
    end
    if (wr_en && prev_wr) dbl_wr++;
    prev_wr = wr_en;
  end

  task automatic clear_q();
    wq_data.delete();
    wq_chan.delete();
    wq_cyc.delete();
    lsb_q.delete();
  endtask

  // Slot bits k0..k1: k=0 is the boundary bit, k=1..DW carry MSB..LSB,
  // the remainder is padding driven to 1.
  task automatic send_bits(input logic lr, input logic [DW-1:0] w,
                           input int k0, input int k1, input logic full);
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      bclk_in   = 1'b0;
      lrck_in   = lr;
      fifo_full = full;
      sd_in     = (k >= 1 && k <= DW) ? w[DW-k] : 1'b1;
      repeat (8) @(negedge clk);
      bclk_in = 1'b1;
      if (k == DW) lsb_q.push_back(cyc);
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic send_half(input logic lr, input logic [DW-1:0] w, input logic full);
    send_bits(lr, w, 0, 31, full);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (wr_en !== 1'b0)   begin nfail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    nvec++; if (wr_data !== '0)   begin nfail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    nvec++; if (wr_chan !== 1'b0) begin nfail++; $display("FAIL reset_wr_chan: got %b want 0", wr_chan); end
    nvec++; if (overrun !== 1'b0) begin nfail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    nvec++; if (frame_err !== 1'b0) begin nfail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Three frames; the first left half has no preceding boundary, so five words.
  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    logic          exp_c;
    clear_q();
    for (int f = 0; f < 3; f++) begin
      send_half(1'b0, 24'hA5A5A5, 1'b0);
      send_half(1'b1, 24'h5A5A5A, 1'b0);
    end
    nvec++; if (wq_data.size() != 5) begin nfail++; $display("FAIL stream_count: got %0d want 5", wq_data.size()); end
    for (int i = 0; i < 5; i++) begin
      exp_c = (i % 2 == 0);
      exp_d = exp_c ? 24'h5A5A5A : 24'hA5A5A5;
      nvec++;
      if (i >= wq_data.size()) begin
        nfail++; $display("FAIL stream_word%0d: got no write want %h", i, exp_d);
      end else begin
        if (wq_data[i] !== exp_d) begin nfail++; $display("FAIL stream_data%0d: got %h want %h", i, wq_data[i], exp_d); end
        nvec++; if (wq_chan[i] !== exp_c) begin nfail++; $display("FAIL stream_chan%0d: got %b want %b", i, wq_chan[i], exp_c); end
        nvec++; if (wq_cyc[i] - lsb_q[i+1] != 3) begin nfail++; $display("FAIL stream_latency%0d: got %0d want 3", i, wq_cyc[i] - lsb_q[i+1]); end
      end
    end
  endtask

  task automatic test_overrun();
    clear_q();
    send_half(1'b0, 24'hA5A5A5, 1'b0);
    send_half(1'b1, 24'h123456, 1'b1);
    fifo_full = 1'b0;
    nvec++; if (wq_data.size() != 1) begin nfail++; $display("FAIL ovr_count: got %0d want 1", wq_data.size()); end
    nvec++; if (overrun !== 1'b1) begin nfail++; $display("FAIL ovr_set: got %b want 1", overrun); end
    nvec++; if (frame_err !== 1'b0) begin nfail++; $display("FAIL ovr_no_ferr: got %b want 0", frame_err); end
    pulse_clr();
    nvec++; if (overrun !== 1'b0) begin nfail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    clear_q();
    send_half(1'b0, 24'h654321, 1'b0);
    nvec++;
    if (wq_data.size() != 1) begin
      nfail++; $display("FAIL ovr_next_count: got %0d want 1", wq_data.size());
    end else begin
      if (wq_data[0] !== 24'h654321) begin nfail++; $display("FAIL ovr_next_data: got %h want 654321", wq_data[0]); end
      nvec++; if (wq_chan[0] !== 1'b0) begin nfail++; $display("FAIL ovr_next_chan: got %b want 0", wq_chan[0]); end
    end
  endtask

  task automatic test_short_frame();
    clear_q();
    send_bits(1'b1, 24'hFFFFFF, 0, 9, 1'b0);
    send_half(1'b0, 24'h3C3C3C, 1'b0);
    nvec++; if (frame_err !== 1'b1) begin nfail++; $display("FAIL short_ferr: got %b want 1", frame_err); end
    nvec++;
    if (wq_data.size() != 1) begin
      nfail++; $display("FAIL short_count: got %0d want 1", wq_data.size());
    end else begin
      if (wq_data[0] !== 24'h3C3C3C) begin nfail++; $display("FAIL short_next_data: got %h want 3c3c3c", wq_data[0]); end
      nvec++; if (wq_chan[0] !== 1'b0) begin nfail++; $display("FAIL short_next_chan: got %b want 0", wq_chan[0]); end
    end
    pulse_clr();
    nvec++; if (frame_err !== 1'b0) begin nfail++; $display("FAIL short_clear: got %b want 0", frame_err); end
  endtask

  task automatic test_long_frame();
    clear_q();
    send_bits(1'b1, 24'h0F0F0F, 0, 39, 1'b0);
    nvec++; if (frame_err !== 1'b1) begin nfail++; $display("FAIL long_ferr: got %b want 1", frame_err); end
    nvec++;
    if (wq_data.size() != 1) begin
      nfail++; $display("FAIL long_count: got %0d want 1", wq_data.size());
    end else if (wq_data[0] !== 24'h0F0F0F || wq_chan[0] !== 1'b1) begin
      nfail++; $display("FAIL long_word: got %b/%h want 1/0f0f0f", wq_chan[0], wq_data[0]);
    end
    pulse_clr();
    clear_q();
    send_half(1'b1, 24'h777777, 1'b0);
    nvec++; if (wq_data.size() != 0) begin nfail++; $display("FAIL long_seek_nowrite: got %0d writes want 0", wq_data.size()); end
    nvec++; if (frame_err !== 1'b0) begin nfail++; $display("FAIL long_seek_ferr: got %b want 0", frame_err); end
    send_half(1'b0, 24'h00FF00, 1'b0);
    nvec++;
    if (wq_data.size() != 1) begin
      nfail++; $display("FAIL long_resync_count: got %0d want 1", wq_data.size());
    end else if (wq_data[0] !== 24'h00FF00 || wq_chan[0] !== 1'b0) begin
      nfail++; $display("FAIL long_resync_word: got %b/%h want 0/00ff00", wq_chan[0], wq_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_half(1'b1, 24'h13579B, 1'b0);
    nvec++;
    if (wq_data.size() != 1 || wq_data[0] !== 24'h13579B) begin
      nfail++; $display("FAIL rstmid_pre: got %0d writes want 1 of 13579b", wq_data.size());
    end
    send_bits(1'b0, 24'hFFFFFF, 0, 12, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (wr_data !== '0) begin nfail++; $display("FAIL rstmid_data: got %h want 0", wr_data); end
    rst = 1'b0;
    clear_q();
    send_bits(1'b0, 24'hFFFFFF, 13, 31, 1'b0);
    send_half(1'b1, 24'h5A5A5A, 1'b0);
    send_half(1'b0, 24'h000001, 1'b0);
    nvec++;
    if (wq_data.size() != 2) begin
      nfail++; $display("FAIL rstmid_count: got %0d want 2", wq_data.size());
    end else begin
      if (wq_data[0] !== 24'h5A5A5A || wq_chan[0] !== 1'b1) begin
        nfail++; $display("FAIL rstmid_first: got %b/%h want 1/5a5a5a", wq_chan[0], wq_data[0]);
      end
      nvec++;
      if (wq_data[1] !== 24'h000001 || wq_chan[1] !== 1'b0) begin
        nfail++; $display("FAIL rstmid_second: got %b/%h want 0/000001", wq_chan[1], wq_data[1]);
      end
    end
  endtask

  task automatic test_enable();
    clear_q();
    enable = 1'b0;
    send_half(1'b1, 24'hABCDEF, 1'b0);
    send_half(1'b0, 24'hABCDEF, 1'b0);
    send_bits(1'b1, 24'h111111, 0, 9, 1'b0);
    nvec++; if (wq_data.size() != 0) begin nfail++; $display("FAIL en_disabled: got %0d writes want 0", wq_data.size()); end
    enable = 1'b1;
    send_bits(1'b1, 24'h111111, 10, 31, 1'b0);
    nvec++; if (wq_data.size() != 0) begin nfail++; $display("FAIL en_midhalf: got %0d writes want 0", wq_data.size()); end
    send_half(1'b0, 24'h222222, 1'b0);
    nvec++;
    if (wq_data.size() != 1) begin
      nfail++; $display("FAIL en_resume_count: got %0d want 1", wq_data.size());
    end else if (wq_data[0] !== 24'h222222 || wq_chan[0] !== 1'b0) begin
      nfail++; $display("FAIL en_resume_word: got %b/%h want 0/222222", wq_chan[0], wq_data[0]);
    end
    nvec++; if (frame_err !== 1'b0) begin nfail++; $display("FAIL en_ferr: got %b want 0", frame_err); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; bclk_in = 1'b0; lrck_in = 1'b0; sd_in = 1'b0;
    fifo_full = 1'b0; clr_err = 1'b0;
    test_reset();
    test_back_to_back();
    test_overrun();
    test_short_frame();
    test_long_frame();
    test_reset_mid();
    test_enable();
    nvec++; if (dbl_wr != 0) begin nfail++; $display("FAIL strobe_width: got %0d multi-cycle strobes want 0", dbl_wr); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
